nabp_image_ram_writer: RTL

Receiving end of the NABP image output stream. Accepts the address/data words produced by the processing-element domino chain and the image addresser, and buffers them in a small FIFO. Drains them into a single-port image RAM that may stall. Drives `ir_enable` back to the producer as flow control, and reports frame completion, written-word count and errors to the host.

---
 rtl/nabp_image_ram_writer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/nabp_image_ram_writer.sv
// nabp_image_ram_writer: buffers NABP image words from the PE chain / addresser and commits them to a stalling single-port image RAM.
// Latency: a word pushed at edge N is presented on mem_* from cycle N+1 at the earliest (FIFO empty).
// Backpressure: registered ir_enable drops once fewer than 2 entries would be free; mem_ready=0 holds the head word stable on mem_*.
//
// Optional feature: define NABP_IMAGE_WRITER_CHECKSUM_EN to get the XOR of all committed
// words on hs_checksum; otherwise hs_checksum is tied to 0 and no checksum register exists.
//
// Ports:
//   clk, reset_n                  - clock (rising edge), asynchronous active-low reset
//   ir_kick / ir_done             - frame start / end pulses from the producer
//   ir_addr_valid, ir_addr, ir_val - image word stream into the FIFO
//   ir_enable                     - producer may advance (one word of slack after it falls)
//   mem_wr_en, mem_addr, mem_wr_data, mem_ready - RAM write port, committed when en && ready
//   hs_done, hs_busy, hs_count, hs_error, hs_checksum - host status

module nabp_image_ram_writer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat,
  output logic [AW:0]      count
);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the count decides what is valid.
  always_ff @(posedge clk) begin
    if (push) ram[wr_ptr] <= wr_dat;
  end

  assign rd_dat = ram[rd_ptr];
endmodule

module nabp_image_ram_writer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ir_kick,
  input  logic              ir_done,
  input  logic              ir_addr_valid,
  input  logic [ADDR_W-1:0] ir_addr,
  input  logic [DATA_W-1:0] ir_val,
  output logic              ir_enable,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_ready,
  output logic              hs_done,
  output logic              hs_busy,
  output logic [ADDR_W:0]   hs_count,
  output logic              hs_error,
  output logic [DATA_W-1:0] hs_checksum
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = ADDR_W + 1;
  localparam int EW = ADDR_W + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN, S_DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] fifo_cnt_nxt;
  logic [EW-1:0] head;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          kick_ok;
  logic          err_set;

  nabp_image_ram_writer_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_dat  ({ir_addr, ir_val}),
    .rd_dat  (head),
    .count   (fifo_cnt)
  );

  assign mem_wr_en = (fifo_cnt != '0);
  assign pop       = mem_wr_en && mem_ready;
  assign fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));
  assign push_req  = (state == S_RECV) && ir_addr_valid;
  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign push      = push_req && (!fifo_full || pop);
  assign kick_ok   = ir_kick && (state == S_IDLE);
  assign fifo_cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);

  assign err_set = (push_req && !push)
                || (ir_addr_valid && (state != S_RECV))
                || (ir_kick && (state != S_IDLE))
                || (ir_done && (state != S_RECV));

  // Head word is only meaningful while the strobe is up; keep the bus quiet otherwise.
  assign mem_addr    = mem_wr_en ? head[EW-1:DATA_W] : '0;
  assign mem_wr_data = mem_wr_en ? head[DATA_W-1:0]  : '0;

  assign hs_done = (state == S_DONE);
  assign hs_busy = (state == S_RECV) || (state == S_DRAIN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ir_kick) state_nxt = S_RECV;
      S_RECV:  if (ir_done) state_nxt = S_DRAIN;
      // Leave as soon as the last pop happens so DONE follows it directly.
      S_DRAIN: if (fifo_cnt_nxt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ir_enable <= 1'b0;
      hs_error  <= 1'b0;
      hs_count  <= '0;
    end else begin
      state     <= state_nxt;
      // Two free entries cover the word the producer may still send after enable falls.
      ir_enable <= (state_nxt == S_RECV) && (fifo_cnt_nxt <= CW'(FIFO_DEPTH - 2));
      hs_error  <= err_set || (hs_error && !kick_ok);
      if (kick_ok)
        hs_count <= '0;
      else if (pop && (hs_count != '1))
        hs_count <= hs_count + HW'(1);
    end
  end

`ifdef NABP_IMAGE_WRITER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      checksum <= '0;
    else if (kick_ok)
      checksum <= '0;
    else if (pop)
      checksum <= checksum ^ mem_wr_data;
  end

  assign hs_checksum = checksum;
`else
  assign hs_checksum = '0;
`endif

endmodule
